// File: rtl/branch_resolve_unit_if.sv
// Issue-side and result-side handshake bundle for the branch resolve unit.
// The master side issues operations and consumes results, while the slave side is the unit itself.
interface branch_resolve_unit_if #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 5
);
    localparam int FUNC_W = 4;

    logic [NUM_CH-1:0]             in_valid;
    logic [NUM_CH-1:0]             in_ready;
    logic [NUM_CH-1:0][31:0]       in_rs1;
    logic [NUM_CH-1:0][31:0]       in_rs2;
    logic [NUM_CH-1:0][FUNC_W-1:0] in_func;
    logic [NUM_CH-1:0][31:0]       in_pc;
    logic [NUM_CH-1:0][31:0]       in_offset;
    logic [NUM_CH-1:0]             in_pred_taken;
    logic [NUM_CH-1:0][31:0]       in_pred_target;
    logic [NUM_CH-1:0][TAG_W-1:0]  in_tag;

    logic [NUM_CH-1:0]             out_valid;
    logic [NUM_CH-1:0]             out_ready;
    logic [NUM_CH-1:0]             out_taken;
    logic [NUM_CH-1:0][31:0]       out_target;
    logic [NUM_CH-1:0][31:0]       out_link;
    logic [NUM_CH-1:0]             out_mispredict;
    logic [NUM_CH-1:0][TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_rs1, in_rs2, in_func, in_pc, in_offset,
               in_pred_taken, in_pred_target, in_tag, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_tag
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_func, in_pc, in_offset,
               in_pred_taken, in_pred_target, in_tag, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_tag
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Multi-channel two-stage branch resolver: S1 captures operands, S2 holds the resolved result.
// A registered redirect is raised for the oldest mispredicting retirement, and the retired mispredicts are counted with saturation.
module branch_resolve_unit #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    branch_resolve_unit_if.slave bus,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [TAG_W-1:0]     redirect_tag,
    output logic [15:0]          mispred_count
);
    localparam logic [3:0] F_EQ   = 4'd0;
    localparam logic [3:0] F_NE   = 4'd1;
    localparam logic [3:0] F_LT   = 4'd2;
    localparam logic [3:0] F_GE   = 4'd3;
    localparam logic [3:0] F_LTU  = 4'd4;
    localparam logic [3:0] F_GEU  = 4'd5;
    localparam logic [3:0] F_JAL  = 4'd6;
    localparam logic [3:0] F_JALR = 4'd7;

    logic [NUM_CH-1:0]            mis_retire;
    logic [NUM_CH-1:0][31:0]      s2_target;
    logic [NUM_CH-1:0][TAG_W-1:0] s2_tag;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic             s1_valid_reg, s1_pred_taken_reg;
        logic [3:0]       s1_func_reg;
        logic [31:0]      s1_rs1_reg, s1_rs2_reg, s1_pc_reg, s1_offset_reg, s1_pred_target_reg;
        logic [TAG_W-1:0] s1_tag_reg;
        logic             s2_valid_reg, s2_taken_reg, s2_mispredict_reg;
        logic [31:0]      s2_target_reg, s2_link_reg;
        logic [TAG_W-1:0] s2_tag_reg;
        logic             s2_load, s1_move, accept;
        logic             taken_next, mispredict_next;
        logic [31:0]      target_next, link_next;

        // S2 can take a new entry when it is empty or its result leaves this cycle.
        assign s2_load          = !s2_valid_reg || bus.out_ready[gi];
        assign s1_move          = s1_valid_reg && s2_load;
        assign bus.in_ready[gi] = !s1_valid_reg || s2_load;
        assign accept           = bus.in_valid[gi] && bus.in_ready[gi] && !flush;

        always_comb begin
            taken_next = 1'b0;
            case (s1_func_reg)
                F_EQ:    taken_next = (s1_rs1_reg == s1_rs2_reg);
                F_NE:    taken_next = (s1_rs1_reg != s1_rs2_reg);
                F_LT:    taken_next = ($signed(s1_rs1_reg) <  $signed(s1_rs2_reg));
                F_GE:    taken_next = ($signed(s1_rs1_reg) >= $signed(s1_rs2_reg));
                F_LTU:   taken_next = (s1_rs1_reg <  s1_rs2_reg);
                F_GEU:   taken_next = (s1_rs1_reg >= s1_rs2_reg);
                F_JAL:   taken_next = 1'b1;
                F_JALR:  taken_next = 1'b1;
                default: taken_next = 1'b0;
            endcase
            link_next = s1_pc_reg + 32'd4;
            if (s1_func_reg == F_JALR)
                target_next = (s1_rs1_reg + s1_offset_reg) & 32'hFFFF_FFFE;
            else if (taken_next)
                target_next = s1_pc_reg + s1_offset_reg;
            else
                target_next = link_next;
            // A correctly predicted not-taken branch ignores the predicted target.
            mispredict_next = (taken_next != s1_pred_taken_reg) ||
                              (taken_next && (target_next != s1_pred_target_reg));
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                s1_valid_reg       <= 1'b0;
                s1_pred_taken_reg  <= 1'b0;
                s1_func_reg        <= '0;
                s1_rs1_reg         <= '0;
                s1_rs2_reg         <= '0;
                s1_pc_reg          <= '0;
                s1_offset_reg      <= '0;
                s1_pred_target_reg <= '0;
                s1_tag_reg         <= '0;
                s2_valid_reg       <= 1'b0;
                s2_taken_reg       <= 1'b0;
                s2_mispredict_reg  <= 1'b0;
                s2_target_reg      <= '0;
                s2_link_reg        <= '0;
                s2_tag_reg         <= '0;
            end else begin
                if (flush)
                    s1_valid_reg <= 1'b0;
                else if (bus.in_ready[gi])
                    s1_valid_reg <= bus.in_valid[gi];
                if (accept) begin
                    s1_pred_taken_reg  <= bus.in_pred_taken[gi];
                    s1_func_reg        <= bus.in_func[gi];
                    s1_rs1_reg         <= bus.in_rs1[gi];
                    s1_rs2_reg         <= bus.in_rs2[gi];
                    s1_pc_reg          <= bus.in_pc[gi];
                    s1_offset_reg      <= bus.in_offset[gi];
                    s1_pred_target_reg <= bus.in_pred_target[gi];
                    s1_tag_reg         <= bus.in_tag[gi];
                end
                if (flush)
                    s2_valid_reg <= 1'b0;
                else if (s2_load)
                    s2_valid_reg <= s1_valid_reg;
                if (!flush && s1_move) begin
                    s2_taken_reg      <= taken_next;
                    s2_mispredict_reg <= mispredict_next;
                    s2_target_reg     <= target_next;
                    s2_link_reg       <= link_next;
                    s2_tag_reg        <= s1_tag_reg;
                end
            end
        end

        assign bus.out_valid[gi]      = s2_valid_reg;
        assign bus.out_taken[gi]      = s2_taken_reg;
        assign bus.out_target[gi]     = s2_target_reg;
        assign bus.out_link[gi]       = s2_link_reg;
        assign bus.out_mispredict[gi] = s2_mispredict_reg;
        assign bus.out_tag[gi]        = s2_tag_reg;
        assign mis_retire[gi]  = s2_valid_reg && bus.out_ready[gi] && s2_mispredict_reg;
        assign s2_target[gi]   = s2_target_reg;
        assign s2_tag[gi]      = s2_tag_reg;
    end

    logic             hit;
    logic [31:0]      sel_pc;
    logic [TAG_W-1:0] sel_tag;
    logic [16:0]      count_sum;

    always_comb begin
        hit       = 1'b0;
        sel_pc    = '0;
        sel_tag   = '0;
        count_sum = {1'b0, mispred_count};
        // Walk from youngest to oldest so the lowest index is the final winner.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mis_retire[c]) begin
                hit     = 1'b1;
                sel_pc  = s2_target[c];
                sel_tag = s2_tag[c];
            end
            count_sum = count_sum + 17'(mis_retire[c]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_tag   <= '0;
            mispred_count  <= '0;
        end else begin
            redirect_valid <= !flush && hit;
            if (!flush && hit) begin
                redirect_pc  <= sel_pc;
                redirect_tag <= sel_tag;
            end
            if (!flush)
                mispred_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of single-op vectors on each channel, plus
// hand sequences for dual retirement, backpressure, flush, reset, and counter saturation.
module tb_branch_resolve_unit;
    localparam int NUM_CH = 2;
    localparam int TAG_W  = 5;

    localparam logic [3:0] F_EQ = 4'd0, F_NE = 4'd1, F_LT = 4'd2, F_GE = 4'd3;
    localparam logic [3:0] F_LTU = 4'd4, F_GEU = 4'd5, F_JAL = 4'd6, F_JALR = 4'd7, F_BAD = 4'd8;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] rs1, rs2, pc, off;
        logic        pt;
        logic [31:0] ptgt;
        logic        etaken;
        logic [31:0] etgt, elink;
        logic        emis;
    } vec_t;

    logic clock, reset, flush;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [TAG_W-1:0] redirect_tag;
    logic [15:0] mispred_count;

    int total = 0;
    int bad   = 0;
    int cnt_model = 0;
    vec_t vt[14];

    branch_resolve_unit_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) bi();

    branch_resolve_unit #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush), .bus(bi.slave),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_tag(redirect_tag), .mispred_count(mispred_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input int c, input vec_t v, input logic [TAG_W-1:0] tag);
        bi.in_func[c]        = v.func;
        bi.in_rs1[c]         = v.rs1;
        bi.in_rs2[c]         = v.rs2;
        bi.in_pc[c]          = v.pc;
        bi.in_offset[c]      = v.off;
        bi.in_pred_taken[c]  = v.pt;
        bi.in_pred_target[c] = v.ptgt;
        bi.in_tag[c]         = tag;
    endtask

    function automatic vec_t jal_op(input logic [31:0] pc, input logic [31:0] off,
                                    input logic pt, input logic [31:0] ptgt);
        vec_t v;
        v = '{F_JAL, 32'd0, 32'd0, pc, off, pt, ptgt, 1'b1, pc + off, pc + 32'd4, 1'b0};
        v.emis = (!pt) || (ptgt != pc + off);
        return v;
    endfunction

    task automatic run_vec(input int c, input int i, input logic [TAG_W-1:0] tag);
        vec_t v;
        v = vt[i];
        @(negedge clock);
        set_op(c, v, tag);
        bi.in_valid[c] = 1'b1;
        #1 chk("in_ready", 32'(bi.in_ready[c]), 32'd1);
        @(negedge clock);
        bi.in_valid[c] = 1'b0;
        #1 chk("latency_early", 32'(bi.out_valid[c]), 32'd0);
        @(negedge clock);
        #1;
        chk("out_valid", 32'(bi.out_valid[c]), 32'd1);
        chk("out_taken", 32'(bi.out_taken[c]), 32'(v.etaken));
        chk("out_target", bi.out_target[c], v.etgt);
        chk("out_link", bi.out_link[c], v.elink);
        chk("out_mispredict", 32'(bi.out_mispredict[c]), 32'(v.emis));
        chk("out_tag", 32'(bi.out_tag[c]), 32'(tag));
        @(negedge clock);
        #1;
        cnt_model += int'(v.emis);
        chk("out_retired", 32'(bi.out_valid[c]), 32'd0);
        chk("redirect_valid", 32'(redirect_valid), 32'(v.emis));
        if (v.emis) begin
            chk("redirect_pc", redirect_pc, v.etgt);
            chk("redirect_tag", 32'(redirect_tag), 32'(tag));
        end
        chk("mispred_count", 32'(mispred_count), 32'(cnt_model));
        @(negedge clock);
        #1 chk("redirect_pulse", 32'(redirect_valid), 32'd0);
        $display("vec ch=%0d idx=%0d tag=%0d target=0x%08h mis=%0d", c, i, tag, v.etgt, v.emis);
    endtask

    task automatic run_dual(input vec_t v0, input vec_t v1, input logic [TAG_W-1:0] t0,
                            input logic [TAG_W-1:0] t1, input logic [31:0] epc,
                            input logic [TAG_W-1:0] etag, input int delta);
        @(negedge clock);
        set_op(0, v0, t0);
        set_op(1, v1, t1);
        bi.in_valid = 2'b11;
        @(negedge clock);
        bi.in_valid = 2'b00;
        @(negedge clock);
        #1 chk("dual_out_valid", 32'(bi.out_valid), 32'h3);
        @(negedge clock);
        #1;
        cnt_model += delta;
        chk("dual_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("dual_redirect_pc", redirect_pc, epc);
        chk("dual_redirect_tag", 32'(redirect_tag), 32'(etag));
        chk("dual_count", 32'(mispred_count), 32'(cnt_model));
        @(negedge clock);
        #1 chk("dual_pulse", 32'(redirect_valid), 32'd0);
        $display("dual tags=%0d/%0d redirect=0x%08h count=%0d", t0, t1, epc, cnt_model);
    endtask

    // Loads both channels with two mispredicting ops each while results are stalled.
    task automatic fill_both();
        bi.out_ready = 2'b00;
        @(negedge clock);
        set_op(0, jal_op(32'h600, 32'h10, 1'b0, 32'h0), 5'd20);
        set_op(1, jal_op(32'h700, 32'h10, 1'b0, 32'h0), 5'd21);
        bi.in_valid = 2'b11;
        @(negedge clock);
        set_op(0, jal_op(32'h800, 32'h10, 1'b0, 32'h0), 5'd22);
        set_op(1, jal_op(32'h900, 32'h10, 1'b0, 32'h0), 5'd23);
        @(negedge clock);
        bi.in_valid = 2'b00;
        #1;
        chk("fill_out_valid", 32'(bi.out_valid), 32'h3);
        chk("fill_in_ready", 32'(bi.in_ready), 32'h0);
    endtask

    task automatic stream(input int k);
        set_op(0, jal_op(32'h0, 32'h40, 1'b0, 32'h0), 5'd1);
        set_op(1, jal_op(32'h0, 32'h40, 1'b0, 32'h0), 5'd2);
        bi.out_ready = 2'b11;
        @(negedge clock);
        bi.in_valid = 2'b11;
        repeat (k) @(negedge clock);
        bi.in_valid = 2'b00;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        vt[0]  = '{F_EQ,   32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 32'h120,  1'b1, 32'h120,  32'h104,      1'b0};
        vt[1]  = '{F_LT,   32'hFFFFFFFF, 32'd1,        32'h100,      32'h20,       1'b0, 32'h0,    1'b1, 32'h120,  32'h104,      1'b1};
        vt[2]  = '{F_LTU,  32'hFFFFFFFF, 32'd1,        32'h100,      32'h20,       1'b0, 32'h0,    1'b0, 32'h104,  32'h104,      1'b0};
        vt[3]  = '{F_JALR, 32'h1003,     32'd0,        32'hFFFFFFFC, 32'h4,        1'b1, 32'h1006, 1'b1, 32'h1006, 32'h0,        1'b0};
        vt[4]  = '{F_NE,   32'd3,        32'd3,        32'h200,      32'h40,       1'b0, 32'hDEAD, 1'b0, 32'h204,  32'h204,      1'b0};
        vt[5]  = '{F_GE,   32'd1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFF0, 1'b1, 32'h2F0,  1'b1, 32'h2F0,  32'h304,      1'b0};
        vt[6]  = '{F_GEU,  32'd1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFF0, 1'b1, 32'h2F0,  1'b0, 32'h304,  32'h304,      1'b1};
        vt[7]  = '{F_JAL,  32'd0,        32'd0,        32'h400,      32'h100,      1'b1, 32'h504,  1'b1, 32'h500,  32'h404,      1'b1};
        vt[8]  = '{F_BAD,  32'd0,        32'd0,        32'h10,       32'h8,        1'b0, 32'h0,    1'b0, 32'h14,   32'h14,       1'b0};
        vt[9]  = '{F_EQ,   32'd1,        32'd2,        32'h500,      32'h10,       1'b0, 32'h0,    1'b0, 32'h504,  32'h504,      1'b0};
        vt[10] = '{F_JAL,  32'd0,        32'd0,        32'hFFFFFFF0, 32'h20,       1'b1, 32'h10,   1'b1, 32'h10,   32'hFFFFFFF4, 1'b0};
        vt[11] = '{F_JALR, 32'h2000,     32'd0,        32'h80,       32'h11,       1'b1, 32'h2011, 1'b1, 32'h2010, 32'h84,       1'b1};
        vt[12] = '{F_LT,   32'd5,        32'd5,        32'h80,       32'h10,       1'b1, 32'h90,   1'b0, 32'h84,   32'h84,       1'b1};
        vt[13] = '{F_LTU,  32'd0,        32'd1,        32'h80,       32'h10,       1'b1, 32'h90,   1'b1, 32'h90,   32'h84,       1'b0};

        reset = 1'b0;
        flush = 1'b0;
        bi.in_valid = '0;
        bi.out_ready = '0;
        for (int c = 0; c < NUM_CH; c++) set_op(c, vt[0], '0);
        #3;
        chk("rst_out_valid", 32'(bi.out_valid), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_count", 32'(mispred_count), 32'd0);
        chk("rst_out_target", bi.out_target[0], 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bi.out_ready = 2'b11;
        #1 chk("rst_in_ready", 32'(bi.in_ready), 32'h3);

        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 14; i++)
                run_vec(c, i, 5'(i + c * 14));

        run_dual(vt[1], vt[2], 5'd3, 5'd4, 32'h120, 5'd3, 1);
        run_dual(vt[1], vt[7], 5'd5, 5'd9, 32'h120, 5'd5, 2);
        run_dual(vt[0], vt[7], 5'd6, 5'd7, 32'h500, 5'd7, 1);

        // Backpressure on channel 0: stall results for five cycles with issue held valid.
        begin
            int next_send = 0;
            int next_recv = 0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                @(negedge clock);
                bi.out_ready[0] = (cyc >= 5);
                bi.in_valid[0] = (next_send < 6);
                set_op(0, jal_op(32'(next_send * 16), 32'h8, 1'b1, 32'(next_send * 16 + 8)),
                       5'(10 + next_send));
                #1;
                if (cyc >= 2 && cyc <= 4) begin
                    chk("bp_in_ready_low", 32'(bi.in_ready[0]), 32'd0);
                    chk("bp_hold_valid", 32'(bi.out_valid[0]), 32'd1);
                    chk("bp_hold_tag", 32'(bi.out_tag[0]), 32'd10);
                end
                if (bi.out_valid[0] && bi.out_ready[0]) begin
                    chk("bp_order_tag", 32'(bi.out_tag[0]), 32'(10 + next_recv));
                    chk("bp_target", bi.out_target[0], 32'(next_recv * 16 + 8));
                    $display("bp retire tag=%0d target=0x%08h", bi.out_tag[0], bi.out_target[0]);
                    next_recv++;
                end
                if (bi.in_valid[0] && bi.in_ready[0]) next_send++;
            end
            bi.in_valid[0] = 1'b0;
            chk("bp_all_received", 32'(next_recv), 32'd6);
            chk("bp_count", 32'(mispred_count), 32'(cnt_model));
        end

        // Flush with both stages full: retirements and the accept that cycle are discarded.
        fill_both();
        @(negedge clock);
        flush = 1'b1;
        bi.out_ready = 2'b11;
        set_op(0, jal_op(32'hA00, 32'h10, 1'b0, 32'h0), 5'd24);
        set_op(1, jal_op(32'hB00, 32'h10, 1'b0, 32'h0), 5'd25);
        bi.in_valid = 2'b11;
        @(negedge clock);
        flush = 1'b0;
        bi.in_valid = 2'b00;
        #1;
        chk("flush_out_valid", 32'(bi.out_valid), 32'd0);
        chk("flush_redirect", 32'(redirect_valid), 32'd0);
        chk("flush_count", 32'(mispred_count), 32'(cnt_model));
        @(negedge clock);
        #1;
        chk("flush_drop_accept", 32'(bi.out_valid), 32'd0);
        chk("flush_redirect2", 32'(redirect_valid), 32'd0);
        chk("flush_count2", 32'(mispred_count), 32'(cnt_model));
        $display("flush done count=%0d", cnt_model);

        // Asynchronous reset mid-flight.
        fill_both();
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        cnt_model = 0;
        chk("mrst_out_valid", 32'(bi.out_valid), 32'd0);
        chk("mrst_out_target", bi.out_target[1], 32'd0);
        chk("mrst_redirect_pc", redirect_pc, 32'd0);
        chk("mrst_redirect_tag", 32'(redirect_tag), 32'd0);
        chk("mrst_count", 32'(mispred_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        bi.out_ready = 2'b11;
        #1;
        chk("mrst_in_ready", 32'(bi.in_ready), 32'h3);
        chk("mrst_out_valid2", 32'(bi.out_valid), 32'd0);
        $display("reset done");

        // Streaming mispredicts on both channels, then push past saturation.
        stream(100);
        chk("stream_count", 32'(mispred_count), 32'd200);
        $display("stream count=%0d", mispred_count);
        stream(32700);
        chk("sat_count", 32'(mispred_count), 32'hFFFF);
        $display("saturate count=0x%04h", mispred_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, multi-channel branch resolution functional unit for the out-of-order core. It takes `NUM_CH` independent branch/jump operations per cycle from issue, evaluates the condition and target, and compares both against the fetch-stage prediction. It returns per-channel results (taken, target, link value, mispredict flag) to complete/writeback with valid/ready backpressure. It raises a single registered redirect for the lowest-index mispredicting channel and keeps a saturating mispredict count.

## Interface
- `NUM_CH`, 2: number of parallel branch channels (1..4); index 0 is oldest in program order within a cycle.
- `TAG_W`, 5: ROB tag width.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `flush` in 1: synchronous squash of all in-flight entries.
- `in_valid` in NUM_CH: per-channel issue valid.
- `in_ready` out NUM_CH: per-channel accept.
- `in_rs1`, `in_rs2` in NUM_CH x 32: operands (`DATA`).
- `in_func` in NUM_CH x `BRANCH_FUNC`: EQ, NE, LT, GE, LTU, GEU, JAL, JALR.
- `in_pc`, `in_offset` in NUM_CH x 32: PC (`ADDR`) and sign-extended immediate.
- `in_pred_taken` in NUM_CH, `in_pred_target` in NUM_CH x 32: fetch prediction.
- `in_tag` in NUM_CH x TAG_W: ROB tag.
- `out_valid` out NUM_CH, `out_ready` in NUM_CH: result handshake.
- `out_taken` out NUM_CH; `out_target`, `out_link` out NUM_CH x 32; `out_mispredict` out NUM_CH; `out_tag` out NUM_CH x TAG_W.
- `redirect_valid` out 1, `redirect_pc` out 32, `redirect_tag` out TAG_W: one-cycle fetch redirect.
- `mispred_count` out 16: saturating count of retired mispredicts.

## Operation
- Two register stages per channel: S1 (operand capture), S2 (result). Channels are independent except for redirect arbitration and the shared counter.
- Condition: EQ/NE equality; LT/GE signed compare; LTU/GEU unsigned; JAL/JALR always taken; undefined func -> not taken.
- Target: JALR -> (rs1 + offset) with bit 0 cleared; other taken -> pc + offset; not taken -> pc + 4. All sums modulo 2^32 (wrap, no overflow flag).
- Link: pc + 4 for every op (meaningful for JAL/JALR only), modulo 2^32.
- Mispredict = (taken != pred_taken) OR (taken AND target != pred_target). Not-taken with matching pred_taken=0 never mispredicts regardless of pred_target.
- Advance: S2[c] loads when empty or `out_ready[c]`; S1[c] moves to S2[c] under that condition; `in_ready[c]` = S1[c] empty or S1[c] moving. No combinational path from `in_valid` to `in_ready`.
- Output handshake (`out_valid & out_ready`) retires the entry.
- Redirect: among channels retiring with mispredict this cycle, lowest index wins; its target and tag are registered to `redirect_pc`/`redirect_tag`; `redirect_valid` pulses for exactly one cycle, next cycle.
- Counter: add the number of mispredicting retirements in the cycle (0..NUM_CH); saturate at 0xFFFF.
- Flush: all S1/S2 valids clear at the edge; retirements in a flush cycle are discarded (no redirect, no count); inputs presented that cycle are not captured; `in_ready` may be high but acceptance is void.

## Timing
- Reset (asynchronous, any time, including mid-flight): all S1/S2 valids 0, `out_valid` 0, `out_*` data 0, `redirect_valid` 0, `redirect_pc` 0, `redirect_tag` 0, `mispred_count` 0; `in_ready` all 1 once reset deasserts.
- Latency: accept at edge N -> `out_valid` high after edge N+1 (visible in cycle N+2 when S2 was free); throughput 1 op/channel/cycle with `out_ready` held high.
- Backpressure: with `out_ready[c]`=0, S2[c] holds stable data; S1[c] fills; `in_ready[c]` drops next cycle; nothing lost or duplicated.
- Redirect: retirement at edge N -> `redirect_valid` high in cycle N+1 only.
- Flush and reset win over all other updates; simultaneous flush and accept: accept dropped.

## Test plan
- BEQ rs1=rs2=5, pc=0x100, offset=0x20, pred_taken=1 pred_target=0x120 -> out_taken=1, target 0x120, mispredict=0, 2-cycle latency, no redirect.
- BLT rs1=0xFFFFFFFF, rs2=1 (taken) vs BLTU same operands (not taken, target pc+4), both pred_taken=0 -> channel 0 mispredict only; redirect_pc=0x120 next cycle; count 1.
- JALR rs1=0x1003, offset=0x4, pc=0xFFFFFFFC -> target 0x1006, link 0x00000000 (wrap).
- Both channels mispredict same cycle -> redirect from channel 0 only; mispred_count +2; count saturates at 0xFFFF.
- out_ready[0]=0 for 5 cycles with in_valid held -> in_ready[0] low after S1 fills, ordered results on release, no loss.
- Flush (and separately reset) with both stages full -> all out_valid 0 next cycle, no redirect, counter unchanged (reset: 0).
